// File: rtl/sa_cg_pkg.sv
// Shared types and constants for the SA clock-gate enable controller.
package sa_cg_pkg;

  typedef enum logic [1:0] {
    ST_ON        = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_OFF       = 2'd2,
    ST_WAKE      = 2'd3
  } cg_state_e;

  // Clock runs and is reported settled straight out of reset.
  localparam logic CG_EN_RST    = 1'b1;
  localparam logic WAKE_ACK_RST = 1'b1;

endpackage

// File: rtl/sa_cg_stat_cnt.sv
// Saturating event counter with synchronous clear; clear beats increment.
module sa_cg_stat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !(&count_q)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/sa_clkgate_ctrl.sv
// Gate-enable controller: idle hysteresis before gating, fixed settle delay
// on wake before acknowledging, plus a saturating gated-cycle statistic.
module sa_clkgate_ctrl
  import sa_cg_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int WAKE_DLY = 2,
  parameter int STAT_W   = 16
) (
  input  logic              sa_core_clk,
  input  logic              sa_core_rstn,
  input  logic              cfg_force_on,
  input  logic [CNT_W-1:0]  cfg_idle_dly,
  input  logic              busy,
  input  logic              wake_req,
  output logic              wake_ack,
  input  logic              test_mode,
  output logic              cg_en,
  output logic              cg_te,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_gated_cycles
);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_DLY);

  cg_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cg_en_q, cg_en_d;
  logic             wake_ack_q, wake_ack_d;
  logic             wake;
  logic             gated;

  assign wake  = busy | wake_req | cfg_force_on;
  assign cg_te = test_mode;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_ON: begin
        if (!wake) begin
          if (cfg_idle_dly == '0) begin
            state_d = ST_OFF;
          end else begin
            state_d = ST_COUNTDOWN;
            cnt_d   = cfg_idle_dly;
          end
        end
      end
      ST_COUNTDOWN: begin
        // A wake on the final countdown edge still wins over gating.
        if (wake) begin
          state_d = ST_ON;
        end else if (cnt_q <= CNT_ONE) begin
          state_d = ST_OFF;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_OFF: begin
        if (wake) begin
          if (WAKE_DLY == 0) begin
            state_d = ST_ON;
          end else begin
            state_d = ST_WAKE;
            cnt_d   = WAKE_LOAD;
          end
        end
      end
      ST_WAKE: begin
        // Settle delay always runs to completion, wake is not re-checked here.
        if (cnt_q <= CNT_ONE) begin
          state_d = ST_ON;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = ST_ON;
    endcase

    cg_en_d    = (state_d != ST_OFF);
    wake_ack_d = (state_d == ST_ON) || (state_d == ST_COUNTDOWN);
  end

  always_ff @(posedge sa_core_clk or negedge sa_core_rstn) begin
    if (!sa_core_rstn) begin
      state_q    <= ST_ON;
      cnt_q      <= '0;
      cg_en_q    <= CG_EN_RST;
      wake_ack_q <= WAKE_ACK_RST;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cg_en_q    <= cg_en_d;
      wake_ack_q <= wake_ack_d;
    end
  end

  assign cg_en    = cg_en_q;
  assign wake_ack = wake_ack_q;
  assign gated    = ~cg_en_q;

  sa_cg_stat_cnt #(
    .W (STAT_W)
  ) u_stat (
    .clk   (sa_core_clk),
    .rst_n (sa_core_rstn),
    .clr   (stat_clr),
    .inc   (gated),
    .count (stat_gated_cycles)
  );

endmodule

// File: doc/sa_clkgate_ctrl.md
# sa_clkgate_ctrl

Enable-side controller for the SA integrated clock-gate cells. It watches a partition's activity and wake requests, applies idle hysteresis before dropping the gate enable, and re-enables the clock with a fixed settle delay before acknowledging. It sits beside each gated partition and drives the E and TE pins of that partition's gate cell. It also keeps a saturating gated-cycle statistic for power reporting.

## Interface

Parameters:
- CNT_W, 8, width of idle/wake counters and of cfg_idle_dly
- WAKE_DLY, 2, cycles between enable re-assertion and wake_ack; 0 is legal
- STAT_W, 16, width of the gated-cycle statistic counter

Ports:
- sa_core_clk  in  1  free-running core clock (ungated side)
- sa_core_rstn  in  1  reset, asynchronous assert, active-low
- cfg_force_on  in  1  level; 1 keeps the clock ungated
- cfg_idle_dly  in  CNT_W  idle cycles required before gating; sampled on entry to COUNTDOWN
- busy  in  1  partition activity, level
- wake_req  in  1  level request for a running clock
- wake_ack  out  1  1 = gated clock running and settled
- test_mode  in  1  scan/test override
- cg_en  out  1  drives the gate cell E pin
- cg_te  out  1  drives the gate cell TE pin; equals test_mode, combinational
- stat_clr  in  1  synchronous clear of stat_gated_cycles
- stat_gated_cycles  out  STAT_W  saturating count of cycles with cg_en=0

## Operation

- wake = busy | wake_req | cfg_force_on.
- States: ON, COUNTDOWN, OFF, WAKE.
- ON: cg_en=1, wake_ack=1. If !wake: if cfg_idle_dly==0, go to OFF; otherwise go to COUNTDOWN and load cnt=cfg_idle_dly.
- COUNTDOWN: cg_en=1, wake_ack=1.
  - If wake, go to ON.
  - Else if cnt==1, go to OFF.
  - Else cnt decrements.
- OFF: cg_en=0, wake_ack=0. If wake: if WAKE_DLY==0, go to ON; otherwise go to WAKE and load cnt=WAKE_DLY.
- WAKE: cg_en=1, wake_ack=0.
  - cnt decrements each cycle; at cnt==1, go to ON.
  - WAKE is not abortable: the settle delay completes even if wake drops.
- test_mode does not alter the FSM. The gate cell ORs TE with E, so the clock runs whenever test_mode=1.
- stat_gated_cycles:
  - Increments every cycle in which the registered cg_en is 0.
  - Saturates at all-ones and never wraps.
  - stat_clr takes priority over increment.
- Reset values: state=ON, cg_en=1, wake_ack=1, cnt=0, stat_gated_cycles=0. Reset mid-gate forces the clock on immediately on assertion.

## Timing

- cg_en and wake_ack are flops decoded from the next state, so there are no combinational paths from inputs to these outputs. The gate cell samples E on the falling edge, which gives glitch-free gating.
- Gating: the first idle cycle is sampled at rising edge k (ON→COUNTDOWN). If idle persists, cg_en falls at edge k+D, where D=cfg_idle_dly ≥ 1. With D=0, cg_en falls at edge k.
- Wake: wake is sampled high in OFF at edge n. cg_en rises at edge n, and wake_ack rises at edge n+WAKE_DLY.
- Simultaneous events:
  - wake high on the same edge that cnt reaches 1 in COUNTDOWN: wake wins, go to ON.
  - cfg_idle_dly changes during COUNTDOWN: ignored until the next entry to COUNTDOWN.
- cg_te has zero latency from test_mode.

## Structure

- Shared package sa_cg_pkg holds:
  - the state enum (ON, COUNTDOWN, OFF, WAKE, 2-bit encoding)
  - reset-value constants for cg_en and wake_ack
- One natural sub-module, sa_cg_stat_cnt: the saturating STAT_W counter with clear, reusable by other power monitors.
- The FSM and the load/decrement counter live in the top module.

## Test plan

- Reset → cg_en=1, wake_ack=1, stat=0. Deassert reset with busy=0 and cfg_idle_dly=4 → cg_en drops exactly 4 edges after the first idle sample; stat then counts 1, 2, 3…
- In COUNTDOWN with cnt=2, pulse busy for 1 cycle → return to ON, cg_en never drops. Next idle period reloads the full cfg_idle_dly.
- In OFF, assert wake_req with WAKE_DLY=2 → cg_en=1 on the same edge, wake_ack=1 two edges later. Drop wake_req during WAKE → WAKE still completes to ON.
- cfg_idle_dly=0 with idle → gate on the first idle edge. WAKE_DLY=0 build → OFF→ON in one edge with wake_ack rising together with cg_en.
- stat near saturation: preload via a long OFF period with STAT_W=4 → holds at 15. Assert stat_clr together with an increment → reads 0.
- test_mode=1 while OFF → cg_te=1 immediately, cg_en stays 0. Assert sa_core_rstn low mid-OFF → cg_en=1 asynchronously.
